// File: rtl/perf_counter_if.sv
// perf_counter_if: bundles the write-back event inputs, control pulses and
// display-facing results of perf_counter into one port.
interface perf_counter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             go;
    logic             clr;
    logic             wb_valid;
    logic             wb_is_jump;
    logic             wb_is_branch;
    logic             wb_branch_taken;
    logic             wb_syscall34;
    logic             wb_halt;
    logic [WIDTH-1:0] syscall_a0;

    logic [WIDTH-1:0] total_cycles;
    logic [WIDTH-1:0] uncondi_branch_num;
    logic [WIDTH-1:0] condi_branch_num;
    logic [WIDTH-1:0] led_data_out;
    logic             led_cpu_enable;
    logic             running;
    logic             halted;

    // Pipeline / controller side.
    modport master (
        output go, clr, wb_valid, wb_is_jump, wb_is_branch, wb_branch_taken,
               wb_syscall34, wb_halt, syscall_a0,
        input  total_cycles, uncondi_branch_num, condi_branch_num,
               led_data_out, led_cpu_enable, running, halted
    );

    // Counter block side.
    modport slave (
        input  go, clr, wb_valid, wb_is_jump, wb_is_branch, wb_branch_taken,
               wb_syscall34, wb_halt, syscall_a0,
        output total_cycles, uncondi_branch_num, condi_branch_num,
               led_data_out, led_cpu_enable, running, halted
    );
endinterface

// File: rtl/perf_counter.sv
// perf_counter: run-cycle / jump / taken-branch counters, syscall-34 LED latch
// and IDLE/RUN/HALTED status feeding the seven-segment display driver.
// Optional feature: define PERF_SATURATE_EN to make counters stick at COUNT_MAX
// instead of wrapping modulo 2^WIDTH.
module perf_counter #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] COUNT_MAX = WIDTH'(32'd99_999_999)
) (
    input  logic          clk,
    input  logic          rst_n,
    perf_counter_if.slave bus
);

`ifdef PERF_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] total_cycles_q, total_cycles_d;
    logic [WIDTH-1:0] uncondi_q, uncondi_d;
    logic [WIDTH-1:0] condi_q, condi_d;
    logic [WIDTH-1:0] led_data_q, led_data_d;
    logic             led_en_q, led_en_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;

    // Counter increment: wraps by default, holds at COUNT_MAX when saturating.
    function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v);
        if (SAT_EN && (v == COUNT_MAX)) begin
            return v;
        end
        return v + WIDTH'(1);
    endfunction

    // Next-state and next-counter logic; clr overrides everything.
    always_comb begin
        state_d        = state_q;
        total_cycles_d = total_cycles_q;
        uncondi_d      = uncondi_q;
        condi_d        = condi_q;
        led_data_d     = led_data_q;
        led_en_d       = led_en_q;

        if (bus.clr) begin
            state_d        = ST_IDLE;
            total_cycles_d = '0;
            uncondi_d      = '0;
            condi_d        = '0;
            led_data_d     = '0;
            led_en_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.go) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    total_cycles_d = bump(total_cycles_q);
                    if (bus.wb_valid && bus.wb_halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        if (bus.wb_valid && bus.wb_is_jump) begin
                            uncondi_d = bump(uncondi_q);
                        end else if (bus.wb_valid && bus.wb_is_branch && bus.wb_branch_taken) begin
                            condi_d = bump(condi_q);
                        end
                        if (bus.wb_valid && bus.wb_syscall34) begin
                            led_data_d = bus.syscall_a0;
                            led_en_d   = 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    if (bus.go) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALTED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            total_cycles_q <= '0;
            uncondi_q      <= '0;
            condi_q        <= '0;
            led_data_q     <= '0;
            led_en_q       <= 1'b0;
            running_q      <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            total_cycles_q <= total_cycles_d;
            uncondi_q      <= uncondi_d;
            condi_q        <= condi_d;
            led_data_q     <= led_data_d;
            led_en_q       <= led_en_d;
            running_q      <= running_d;
            halted_q       <= halted_d;
        end
    end

    assign bus.total_cycles       = total_cycles_q;
    assign bus.uncondi_branch_num = uncondi_q;
    assign bus.condi_branch_num   = condi_q;
    assign bus.led_data_out       = led_data_q;
    assign bus.led_cpu_enable     = led_en_q;
    assign bus.running            = running_q;
    assign bus.halted             = halted_q;

endmodule
